// File: rtl/mealy_model_4_pkg.sv
// Shared types and defaults for the 1-0-1-0 Mealy sequence detector.
package mealy_model_4_pkg;

  // Binary state encoding: how much of the pattern has been seen so far.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam bit OVERLAP_DEFAULT = 1'b1;

endpackage

// File: rtl/mealy_model_4.sv
// Mealy detector for the serial pattern 1-0-1-0; out is combinational from state and x.
module mealy_model_4
  import mealy_model_4_pkg::*;
#(
  parameter bit OVERLAP = OVERLAP_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic out
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S0;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S0;
    out        = 1'b0;
    case (state)
      S0: next_state = x ? S1 : S0;
      S1: next_state = x ? S1 : S2;
      S2: next_state = x ? S3 : S0;
      S3: begin
        if (x) begin
          next_state = S1;
        end else begin
          // The trailing "10" of a match is already the start of the next one.
          next_state = OVERLAP ? S2 : S0;
          out        = 1'b1;
        end
      end
      default: begin
        next_state = S0;
        out        = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mealy_model_4.sv
// Self-checking bench for mealy_model_4: directed table, async-reset corner, random vs model.
module tb_mealy_model_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic out_ov;
  logic out_no;

  int checks   = 0;
  int failures = 0;

  mealy_model_4 #(.OVERLAP(1'b1)) dut_ov (.clk(clk), .rst(rst), .x(x), .out(out_ov));
  mealy_model_4 #(.OVERLAP(1'b0)) dut_no (.clk(clk), .rst(rst), .x(x), .out(out_no));

  always #100 clk = ~clk;

  typedef struct {
    string name;
    bit    rst;
    bit    x;
    bit    exp_ov;
    bit    exp_no;
  } vec_t;

  vec_t vecs[$];

  bit hist_ov[$];
  bit hist_no[$];

  // Drive on the falling edge so the DUT sees stable inputs at the next rising edge.
  task automatic applyStimulus(input bit rv, input bit xv);
    @(negedge clk);
    rst = rv;
    x   = xv;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input bit expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: out=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  // Pattern completes when the last three accepted bits are 1,0,1 and the current bit is 0.
  function automatic bit predict(input bit h[$], input bit xv);
    int n = h.size();
    return (n >= 3) && h[n-3] && !h[n-2] && h[n-1] && !xv;
  endfunction

  initial begin
    bit rv, xv, e_ov, e_no;

    vecs = '{
      '{"rst_x1",   1, 1, 0, 0},
      '{"rst_x0",   1, 0, 0, 0},
      '{"basic_b1", 0, 1, 0, 0},
      '{"basic_b2", 0, 0, 0, 0},
      '{"basic_b3", 0, 1, 0, 0},
      '{"basic_b4", 0, 0, 1, 1},
      '{"ovl_b5",   0, 1, 0, 0},
      '{"ovl_b6",   0, 0, 1, 0},
      '{"ovl_b7",   0, 1, 0, 0},
      '{"ovl_b8",   0, 0, 1, 1},
      '{"rst_mid",  1, 0, 0, 0},
      '{"nm1_b1",   0, 1, 0, 0},
      '{"nm1_b2",   0, 1, 0, 0},
      '{"nm1_b3",   0, 0, 0, 0},
      '{"nm1_b4",   0, 0, 0, 0},
      '{"nm1_b5",   0, 1, 0, 0},
      '{"nm1_b6",   0, 0, 0, 0},
      '{"nm1_b7",   0, 1, 0, 0},
      '{"nm1_b8",   0, 1, 0, 0},
      '{"nm1_b9",   0, 0, 0, 0},
      '{"rst_nm2",  1, 0, 0, 0},
      '{"nm2_b1",   0, 1, 0, 0},
      '{"nm2_b2",   0, 1, 0, 0},
      '{"nm2_b3",   0, 0, 0, 0},
      '{"nm2_b4",   0, 1, 0, 0},
      '{"nm2_b5",   0, 0, 1, 1}
    };

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].x);
      checkOutput({vecs[i].name, "_ov"}, out_ov, vecs[i].exp_ov);
      checkOutput({vecs[i].name, "_no"}, out_no, vecs[i].exp_no);
    end

    // Asynchronous reset while out is high must drop out without a clock edge.
    applyStimulus(1, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("s3_pre_ov", out_ov, 1'b1);
    checkOutput("s3_pre_no", out_no, 1'b1);
    #40;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ov", out_ov, 1'b0);
    checkOutput("async_rst_no", out_no, 1'b0);
    applyStimulus(0, 0);
    checkOutput("post_rst1_ov", out_ov, 1'b0);
    checkOutput("post_rst1_no", out_no, 1'b0);
    applyStimulus(0, 0);
    checkOutput("post_rst2_ov", out_ov, 1'b0);
    checkOutput("post_rst2_no", out_no, 1'b0);

    // Random stream against the history-based reference model.
    applyStimulus(1, 0);
    hist_ov.delete();
    hist_no.delete();
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(31) == 0);
      xv = ($urandom_range(3) != 0) ? bit'(i % 2 == 0) : bit'($urandom_range(1));
      applyStimulus(rv, xv);
      e_ov = rv ? 1'b0 : predict(hist_ov, xv);
      e_no = rv ? 1'b0 : predict(hist_no, xv);
      checkOutput("rand_ov", out_ov, e_ov);
      checkOutput("rand_no", out_no, e_no);
      if (rv) begin
        hist_ov.delete();
        hist_no.delete();
      end else begin
        hist_ov.push_back(xv);
        if (hist_ov.size() > 3) void'(hist_ov.pop_front());
        if (e_no) begin
          hist_no.delete();
        end else begin
          hist_no.push_back(xv);
          if (hist_no.size() > 3) void'(hist_no.pop_front());
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
